regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and sequencer for the 16x16 register file. Three writeback sources (0 = ALU, 1 = load unit, 2 = special/immediate unit) compete for the single register-file write port. The block grants one source per cycle with a valid/ready handshake and registers the winning write. It drives the register file's `add_Rd` / `data_wr` / `regwr` inputs one cycle after acceptance.

## Interface
- `DW`, 16, data width of a write.
- `AW`, 4, register address width (16 registers).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  3  per-source write request; bit i belongs to source i.
- `req_addr`  in  3*AW  destination registers, source i at bits [i*AW +: AW].
- `req_data`  in  3*DW  write data, source i at bits [i*DW +: DW].
- `req_ready`  out  3  one-hot grant; a write is accepted when `req_valid[i] & req_ready[i]`.
- `wb_stall`  in  1  freezes arbitration; no source is granted while high.
- `add_Rd`  out  AW  registered destination to the register file.
- `data_wr`  out  DW  registered write data to the register file.
- `regwr`  out  1  registered write enable to the register file.
- `grant_id`  out  2  index of the source whose write is on the outputs this cycle; 2'b11 when idle.
- `r0_drop_cnt`  out  8  count of accepted writes addressed to R0.

## Operation
- Arbitration is combinational, over `req_valid`, the priority pointer `ptr` (0..2) and `wb_stall`.
- At most one `req_ready` bit is high in any cycle.
- The grant goes to the first valid source in the order `ptr`, `ptr+1`, `ptr+2` (mod 3).
- `req_ready` is all zero when `wb_stall=1` or when no source is valid.
- Acceptance of source g:
  - The output register loads `add_Rd = req_addr[g]` and `data_wr = req_data[g]`.
  - `grant_id` loads g.
  - `regwr` loads 1, or 0 when the address is 0 (writes to R0 are swallowed).
  - `ptr` loads (g+1) mod 3.
- If the accepted address is 0, `r0_drop_cnt` increments, saturating at 255.
- A cycle with no acceptance loads `regwr=0` and `grant_id=2'b11`.
  - `add_Rd` and `data_wr` hold their previous values.
  - `ptr` is unchanged.
- Requester rules:
  - A requester keeps `req_valid`, `req_addr` and `req_data` stable until accepted.
  - The arbiter never drops or duplicates an accepted write.
- Sources that are not valid do not move the pointer. A lone requester is granted every cycle, one write per cycle.

## Timing
- Reset values:
  - `ptr=0`, `regwr=0`, `add_Rd=0`, `data_wr=0`, `grant_id=2'b11`, `r0_drop_cnt=0`.
  - `req_ready` is 0 during the reset cycle regardless of `req_valid`.
- Latency: a write accepted in cycle N appears on `add_Rd`/`data_wr`/`regwr` in cycle N+1. The register file commits it at the edge ending cycle N+1.
- Throughput: one write per cycle, sustained.
- `wb_stall` acts in the same cycle: ready drops the cycle stall rises, and no acceptance occurs. Output contents already registered still complete normally.
- Reset mid-operation: an accepted write sitting in the output register is discarded (`regwr=0` after reset). Requesters not yet accepted must re-present their requests.
- Simultaneous requests: the source at `ptr` wins.
  - Example with `ptr=0`: all three valid gives order 0, 1, 2, 0…
  - Each source waits at most 2 cycles behind the others while `wb_stall=0`.

## Configuration
- `WB_RR_ARB_EN` defined: round-robin arbitration with the rotating `ptr`, as described above.
- `WB_RR_ARB_EN` undefined: fixed priority, source 0 > 1 > 2.
  - `ptr` is not implemented; its value reads as a constant 0.
  - All other behaviour (handshake, latency, R0 suppression, counter) is identical.

## Test plan
- Reset then idle:
  - Assert `rst` for 2 cycles with `req_valid=3'b111` → `req_ready=0` and `regwr=0`.
  - After release, with `req_valid=3'b000` → `grant_id=2'b11` and `r0_drop_cnt=0`.
- Single source:
  - Source 1 requests R5=16'hBEEF in cycle N → `req_ready=3'b010` in N.
  - Cycle N+1 shows `regwr=1`, `add_Rd=5`, `data_wr=16'hBEEF`, `grant_id=1`.
- Round-robin (`WB_RR_ARB_EN` defined):
  - All three hold valid for 6 cycles → grants 0, 1, 2, 0, 1, 2.
  - Each write appears on the outputs one cycle later.
  - Fixed-priority build under the same stimulus → source 0 is granted every cycle.
- R0 suppression:
  - Source 0 writes R0=16'h1234 three times → `regwr=0` on each following cycle, `r0_drop_cnt=3`.
  - Source 0 then writes 255 more times to R0 → `r0_drop_cnt` saturates at 255.
- Stall:
  - `wb_stall=1` for 3 cycles with source 2 valid → `req_ready=0` and `regwr=0` throughout.
  - First cycle after stall drops → source 2 is accepted.
- Reset mid-operation:
  - Accept a write to R7 in cycle N, assert `rst` in N+1 → `regwr=0` in N+2, and R7 is not written.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 16x16 register file: three writeback sources, one registered write per cycle.
// Build option WB_RR_ARB_EN selects round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module regfile_wb_arbiter #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_valid,
    input  logic [3*AW-1:0]   req_addr,
    input  logic [3*DW-1:0]   req_data,
    output logic [2:0]        req_ready,
    input  logic              wb_stall,
    output logic [AW-1:0]     add_Rd,
    output logic [DW-1:0]     data_wr,
    output logic              regwr,
    output logic [1:0]        grant_id,
    output logic [7:0]        r0_drop_cnt
);
    localparam int NSRC = 3;

    logic [AW-1:0] src_addr [NSRC];
    logic [DW-1:0] src_data [NSRC];
    logic [1:0]    order_idx [NSRC];
    logic [1:0]    ptr;

    logic [1:0]    grant_idx;
    logic          grant_any;
    logic          accept;

    logic [AW-1:0] add_rd_reg, add_rd_next;
    logic [DW-1:0] data_wr_reg, data_wr_next;
    logic          regwr_reg, regwr_next;
    logic [1:0]    grant_id_reg, grant_id_next;
    logic [7:0]    r0_cnt_reg, r0_cnt_next;

`ifdef WB_RR_ARB_EN
    logic [1:0] ptr_reg, ptr_next;
    assign ptr = ptr_reg;
`else
    assign ptr = 2'd0;
`endif

    // order_idx[k] is the source examined k-th, starting from the pointer (mod 3)
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [2:0] order_sum;
            assign src_addr[gi]  = req_addr[gi*AW +: AW];
            assign src_data[gi]  = req_data[gi*DW +: DW];
            assign order_sum     = {1'b0, ptr} + 3'(gi);
            assign order_idx[gi] = (order_sum >= 3'd3) ? 2'(order_sum - 3'd3) : order_sum[1:0];
            assign req_ready[gi] = accept && (grant_idx == 2'(gi));
        end
    endgenerate

    // Scan from the lowest-priority slot upward so the highest-priority valid source wins last
    always_comb begin
        grant_idx = 2'd0;
        grant_any = 1'b0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (req_valid[order_idx[k]]) begin
                grant_idx = order_idx[k];
                grant_any = 1'b1;
            end
        end
    end

    assign accept = grant_any && !wb_stall && !rst;

    always_comb begin
        add_rd_next   = add_rd_reg;
        data_wr_next  = data_wr_reg;
        regwr_next    = 1'b0;
        grant_id_next = 2'b11;
        r0_cnt_next   = r0_cnt_reg;
        if (accept) begin
            add_rd_next   = src_addr[grant_idx];
            data_wr_next  = src_data[grant_idx];
            regwr_next    = |src_addr[grant_idx];
            grant_id_next = grant_idx;
            if (src_addr[grant_idx] == '0 && r0_cnt_reg != 8'hFF)
                r0_cnt_next = r0_cnt_reg + 8'd1;
        end
    end

`ifdef WB_RR_ARB_EN
    always_comb begin
        ptr_next = ptr_reg;
        if (accept)
            ptr_next = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr_reg <= 2'd0;
        else
            ptr_reg <= ptr_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            add_rd_reg   <= '0;
            data_wr_reg  <= '0;
            regwr_reg    <= 1'b0;
            grant_id_reg <= 2'b11;
            r0_cnt_reg   <= 8'd0;
        end else begin
            add_rd_reg   <= add_rd_next;
            data_wr_reg  <= data_wr_next;
            regwr_reg    <= regwr_next;
            grant_id_reg <= grant_id_next;
            r0_cnt_reg   <= r0_cnt_next;
        end
    end

    // A write still in the output register when reset arrives must not reach the register file
    assign regwr       = regwr_reg && !rst;
    assign add_Rd      = add_rd_reg;
    assign data_wr     = data_wr_reg;
    assign grant_id    = grant_id_reg;
    assign r0_drop_cnt = r0_cnt_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed test-plan steps, then random traffic against a reference model.
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_stall;
    logic [3:0]  add_Rd;
    logic [15:0] data_wr;
    logic        regwr;
    logic [1:0]  grant_id;
    logic [7:0]  r0_drop_cnt;

    int checks;
    int failures;

    // Reference model state: what the output register should hold
    int          m_ptr;
    int          m_cnt;
    int          m_gid;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    bit          m_regwr;
    int          last_win;

    // Random-phase requesters
    bit          pv [3];
    logic [3:0]  pa [3];
    logic [15:0] pd [3];

    regfile_wb_arbiter #(.DW(16), .AW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wb_stall    (wb_stall),
        .add_Rd      (add_Rd),
        .data_wr     (data_wr),
        .regwr       (regwr),
        .grant_id    (grant_id),
        .r0_drop_cnt (r0_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_cnt   = 0;
        m_gid   = 3;
        m_addr  = '0;
        m_data  = '0;
        m_regwr = 0;
    endtask

    // One clock cycle: drive, compare against model, advance model, cross the edge.
    task automatic run_cycle(input logic [2:0] v, input logic [11:0] a, input logic [47:0] d,
                             input logic st, input logic r);
        logic [2:0] exp_ready;
        int win;
        int s;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        wb_stall  = st;
        rst       = r;
        #2;
        win = -1;
        if (!r && !st) begin
            for (int k = 0; k < 3; k++) begin
                s = (m_ptr + k) % 3;
                if (win < 0 && v[s]) win = s;
            end
        end
        exp_ready = 3'b000;
        if (win >= 0) exp_ready[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("regwr", 64'(regwr), 64'(m_regwr && !r));
        chk("add_Rd", 64'(add_Rd), 64'(m_addr));
        chk("data_wr", 64'(data_wr), 64'(m_data));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("r0_drop_cnt", 64'(r0_drop_cnt), 64'(m_cnt));
        if (r) begin
            model_reset();
        end else if (win >= 0) begin
            m_addr  = a[win*4 +: 4];
            m_data  = d[win*16 +: 16];
            m_regwr = (m_addr != 0);
            m_gid   = win;
            if (m_addr == 0 && m_cnt < 255) m_cnt++;
`ifdef WB_RR_ARB_EN
            m_ptr = (win + 1) % 3;
`endif
        end else begin
            m_regwr = 0;
            m_gid   = 3;
        end
        last_win = win;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  v;
        logic [11:0] a;
        logic [47:0] d;
        checks   = 0;
        failures = 0;
        model_reset();
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        wb_stall  = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with all sources requesting, then idle
        run_cycle(3'b111, 12'h321, 48'h3333_2222_1111, 1'b0, 1'b1);
        run_cycle(3'b111, 12'h321, 48'h3333_2222_1111, 1'b0, 1'b1);
        run_cycle(3'b000, 12'h000, 48'h0, 1'b0, 1'b0);
        run_cycle(3'b000, 12'h000, 48'h0, 1'b0, 1'b0);

        // Lone source 1 writing R5
        run_cycle(3'b010, 12'h050, 48'h0000_BEEF_0000, 1'b0, 1'b0);
        chk("single_regwr", 64'(regwr), 64'd1);
        chk("single_addr", 64'(add_Rd), 64'd5);
        chk("single_data", 64'(data_wr), 64'hBEEF);
        chk("single_gid", 64'(grant_id), 64'd1);
        run_cycle(3'b000, 12'h000, 48'h0, 1'b0, 1'b0);

        // All three contending for six cycles
        for (int i = 0; i < 6; i++)
            run_cycle(3'b111, 12'h321, 48'hC003_B002_A001, 1'b0, 1'b0);
        run_cycle(3'b000, 12'h000, 48'h0, 1'b0, 1'b0);

        // Writes to R0 are swallowed and counted, saturating
        for (int i = 0; i < 3; i++)
            run_cycle(3'b001, 12'h000, 48'h0000_0000_1234, 1'b0, 1'b0);
        chk("r0_cnt_3", 64'(r0_drop_cnt), 64'd3);
        for (int i = 0; i < 255; i++)
            run_cycle(3'b001, 12'h000, 48'h0000_0000_1234, 1'b0, 1'b0);
        run_cycle(3'b000, 12'h000, 48'h0, 1'b0, 1'b0);
        chk("r0_cnt_sat", 64'(r0_drop_cnt), 64'd255);

        // Stall holds off source 2 for three cycles
        for (int i = 0; i < 3; i++)
            run_cycle(3'b100, 12'h900, 48'h5A5A_0000_0000, 1'b1, 1'b0);
        run_cycle(3'b100, 12'h900, 48'h5A5A_0000_0000, 1'b0, 1'b0);
        run_cycle(3'b000, 12'h000, 48'h0, 1'b0, 1'b0);

        // Reset lands while a write to R7 sits in the output register
        run_cycle(3'b001, 12'h007, 48'h0000_0000_7777, 1'b0, 1'b0);
        run_cycle(3'b000, 12'h000, 48'h0, 1'b0, 1'b1);
        run_cycle(3'b000, 12'h000, 48'h0, 1'b0, 1'b0);

        // Random traffic; requesters hold each request until it is accepted
        for (int s = 0; s < 3; s++) pv[s] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < 3; s++) begin
                if (!pv[s] && $urandom_range(0, 1) == 1) begin
                    pv[s] = 1;
                    pa[s] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                    pd[s] = 16'($urandom);
                end
            end
            v = {pv[2], pv[1], pv[0]};
            a = {pa[2], pa[1], pa[0]};
            d = {pd[2], pd[1], pd[0]};
            run_cycle(v, a, d, ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) == 0));
            if (last_win >= 0) pv[last_win] = 0;
        end
        run_cycle(3'b000, 12'h000, 48'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
